sha3_arbiter: RTL and testbench
===============================

# sha3_arbiter

Round-robin scheduler that shares one `keccak` hashing core and its single memory-read port between `NREQ` requesters, such as the encrypt and decapsulation units that each need a SHA3-512 digest. It grants the core to one requester at a time and clears the core before each job. It launches the job, routes the core's address and data between the core and the granted requester's memory, and returns a registered 512-bit digest with a one-cycle `done` pulse. A watchdog aborts jobs that never complete.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, ≥2.
- `WIDTH`, 8: memory word width; must equal the core's `m*digit`.
- `AW`, 8: memory address width; must equal the core's address width.
- `TMO`, 4096: maximum BUSY cycles before abort, ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  NREQ  per-requester hash request; level, held until `done` or `err`.
- `gnt`  out  NREQ  one-hot grant, registered.
- `done`  out  NREQ  one-cycle completion pulse to the granted requester.
- `err`  out  NREQ  one-cycle timeout pulse to the granted requester.
- `digest`  out  512  last completed digest, registered.
- `req_addr`  out  AW  read address broadcast to all requester memories.
- `req_din`  in  NREQ*WIDTH  read data; slice k covers bits [k*WIDTH +: WIDTH].
- `k_rst_b`  out  1  active-low reset to the core.
- `k_in_ready`  out  1  start pulse to the core.
- `k_mem_addr`  in  AW  core read address.
- `k_mem_din`  out  WIDTH  core read data.
- `k_out_usr`  in  512  core digest.
- `k_out_ready`  in  1  core completion.

## Operation
The FSM has five states: IDLE, CLR, LAUNCH, BUSY, DONE.

- **IDLE**
  - If `req` != 0, pick the winner by round robin.
  - The search starts at index `ptr`, wraps modulo NREQ, and takes the first set bit.
  - Register `gnt` = onehot(winner) and go to CLR.
  - If `req` == 0, stay in IDLE.
- **CLR**: drive `k_rst_b`=0 for exactly one cycle to clear the permutation state, then go to LAUNCH.
- **LAUNCH**: drive `k_in_ready`=1 for exactly one cycle, clear the watchdog counter, then go to BUSY.
- **BUSY**
  - If `k_out_ready`=1: register `digest` ← `k_out_usr` and go to DONE.
  - Otherwise, if the watchdog counter reaches `TMO`-1: pulse `err`[winner], clear `gnt`, set `ptr` ← winner+1 (mod NREQ), and go to IDLE.
  - Otherwise, increment the watchdog counter.
- **DONE**: pulse `done`[winner], clear `gnt`, set `ptr` ← winner+1 (mod NREQ), and go to IDLE.

Datapath rules:
- Routing is combinational and active whenever `gnt` != 0:
  - `req_addr` = `k_mem_addr`.
  - `k_mem_din` = `req_din` slice of the granted requester.
- When `gnt` == 0: `req_addr`=0 and `k_mem_din`=0.
- `k_rst_b`=1 in every state except CLR, and it is also low while `rst`=1.
- A job is not abortable by the requester. If `req`[winner] drops mid-job, the job still runs to DONE and the `done` pulse is still issued.
- A requester that raises `req` during the grant of another requester is considered at the next IDLE.
- `done` and `err` are never high together, and never high for a non-granted index.
- The watchdog counter is `$clog2(TMO)`+1 bits wide and saturates; it never wraps.

## Timing
Reset values (synchronous, `rst`=1):
- State IDLE, `ptr`=0.
- `gnt`=0, `done`=0, `err`=0, `digest`=0.
- `k_in_ready`=0, `k_rst_b`=0.

Cycle-level behaviour:
- `req` high at edge t (in IDLE) → `gnt` high from t+1, `k_rst_b` low in cycle t+1, `k_in_ready` high in cycle t+2.
- `k_out_ready` sampled high at edge u → `digest` valid and `done` high in cycle u+1; `gnt` falls at u+2.
- The earliest next grant is at edge u+2, so there is one IDLE cycle between jobs.
- `digest` holds its value until the next DONE; a timeout does not change it.
- `k_out_ready` is ignored outside BUSY.
- Reset mid-job returns the block to IDLE with `ptr`=0, and holds the core in reset while `rst`=1.

## Structure
- Package `sha3_arb_pkg`:
  - state enum `arb_state_t` {IDLE, CLR, LAUNCH, BUSY, DONE};
  - `DIGEST_W`=512.
- Sub-module `rr_arbiter`: parameter `NREQ`, inputs `req` and `ptr`, one-hot output `win`. It is combinational, implemented as a double-width masked priority encoder.
- The top level holds the FSM, the watchdog, the digest register and the muxes.

## Test plan
- **Single request**: NREQ=2, `req`=01, core model asserts `k_out_ready` 30 cycles after `k_in_ready` with `k_out_usr`=0xA5…A5. Expect:
  - `gnt`=01;
  - one `k_rst_b` low cycle, then one `k_in_ready` cycle;
  - `done`=01 for exactly 1 cycle, with `digest`=0xA5…A5.
- **Contention**: `req`=11 held continuously. Expect grant order 01, 10, 01; each job complete before the next `gnt`; one IDLE cycle between jobs.
- **Address routing**: during requester 1's job, drive `k_mem_addr`=0x13 with `req_din`={0x77,0x22}. Expect `req_addr`=0x13 and `k_mem_din`=0x77.
- **Timeout**: with TMO=16, the core never asserts ready. Expect:
  - `err`=01 pulse 16 cycles after LAUNCH;
  - `digest` unchanged;
  - `ptr` advanced, so with `req`=11 the next grant is 10.
- **Request drop**: drop `req`[0] mid-BUSY. Expect the job to complete and `done`=01 to pulse.
- **Reset mid-job**: assert `rst` during BUSY. Expect:
  - all outputs at reset values next cycle, with `k_rst_b`=0 while `rst`=1;
  - after release with `req`=10, the first grant is 10.

Source files
------------

// File: rtl/sha3_arb_pkg.sv
// sha3_arb_pkg
// Shared types and constants for the SHA3 core arbiter.
//   arb_state_t : arbiter FSM state encoding
//   DIGEST_W    : width of the keccak digest returned to requesters
package sha3_arb_pkg;

   localparam int DIGEST_W = 512;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      LAUNCH = 3'd2,
      BUSY   = 3'd3,
      DONE   = 3'd4
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: the first set request bit at or after
// index ptr, wrapping modulo NREQ.
//   req : request vector
//   ptr : index where the search starts
//   win : one-hot winner (all zero when req is zero)
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         win
);

   // The request vector is laid out twice. Bits below ptr in the lower copy
   // are masked off, so the lowest surviving bit is the next requester in
   // round-robin order, and the upper copy supplies the wrap-around.
   logic [2*NREQ-1:0] dbl;
   logic [2*NREQ-1:0] masked;
   logic              found;

   assign dbl = {req, req};

   genvar gi;
   generate
      for (gi = 0; gi < 2*NREQ; gi++) begin : g_mask
         assign masked[gi] = dbl[gi] && (gi >= int'(ptr));
      end
   endgenerate

   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < 2*NREQ; i++) begin
         if (masked[i] && !found) begin
            win[i % NREQ] = 1'b1;
            found         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sha3_arbiter.sv
// sha3_arbiter
// Shares one keccak core and its memory-read port between NREQ requesters.
// Each job: grant (round robin), clear the core, launch it, wait for the
// digest under a watchdog, then pulse done (or err on timeout).
//   clk, rst            : clock, synchronous active-high reset
//   req / gnt           : level request per requester / registered one-hot grant
//   done / err          : one-cycle completion / timeout pulse to the winner
//   digest              : last completed digest
//   req_addr / req_din  : memory read port toward the requesters
//   k_rst_b, k_in_ready : active-low clear and start pulse to the core
//   k_mem_addr/k_mem_din: core memory read port
//   k_out_usr/k_out_ready: core digest and completion flag
module sha3_arbiter
   import sha3_arb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int WIDTH = 8,
   parameter int AW    = 8,
   parameter int TMO   = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [NREQ-1:0]       err,
   output logic [DIGEST_W-1:0]   digest,
   output logic [AW-1:0]         req_addr,
   input  logic [NREQ*WIDTH-1:0] req_din,
   output logic                  k_rst_b,
   output logic                  k_in_ready,
   input  logic [AW-1:0]         k_mem_addr,
   output logic [WIDTH-1:0]      k_mem_din,
   input  logic [DIGEST_W-1:0]   k_out_usr,
   input  logic                  k_out_ready
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TMO) + 1;
   localparam logic [CW-1:0] WD_LAST = CW'(TMO - 1);

   arb_state_t          state_reg;
   logic [PW-1:0]       ptr_reg;
   logic [NREQ-1:0]     gnt_reg;
   logic [DIGEST_W-1:0] digest_reg;
   logic [CW-1:0]       wd_reg;

   logic [NREQ-1:0]     win;
   logic [PW-1:0]       gnt_idx;
   logic [PW-1:0]       ptr_next;
   logic                timeout;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req (req),
      .ptr (ptr_reg),
      .win (win)
   );

   // Index of the current winner, recovered from the one-hot grant.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_reg[i]) gnt_idx = PW'(i);
      end
   end

   assign ptr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

   // Completion wins over timeout when both land in the same cycle.
   assign timeout = (state_reg == BUSY) && !k_out_ready && (wd_reg == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         gnt_reg    <= '0;
         digest_reg <= '0;
         wd_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|req) begin
                  gnt_reg   <= win;
                  state_reg <= CLR;
               end
            end
            CLR: state_reg <= LAUNCH;
            LAUNCH: begin
               wd_reg    <= '0;
               state_reg <= BUSY;
            end
            BUSY: begin
               if (k_out_ready) begin
                  digest_reg <= k_out_usr;
                  state_reg  <= DONE;
               end else if (wd_reg == WD_LAST) begin
                  gnt_reg   <= '0;
                  ptr_reg   <= ptr_next;
                  state_reg <= IDLE;
               end else if (wd_reg != {CW{1'b1}}) begin
                  wd_reg <= wd_reg + 1'b1;
               end
            end
            DONE: begin
               gnt_reg   <= '0;
               ptr_reg   <= ptr_next;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign gnt        = gnt_reg;
   assign digest     = digest_reg;
   assign done       = (state_reg == DONE) ? gnt_reg : '0;
   assign err        = timeout ? gnt_reg : '0;
   assign k_in_ready = (state_reg == LAUNCH);
   // Core is held in reset both in CLR and for as long as rst is asserted.
   assign k_rst_b    = !rst && (state_reg != CLR);

   // Memory routing: each slice is gated by its grant bit, then OR-merged;
   // with a one-hot grant at most one slice is non-zero.
   logic [WIDTH-1:0] din_sel [NREQ];
   logic [WIDTH-1:0] din_or;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_route
         assign din_sel[gi] = gnt_reg[gi] ? req_din[gi*WIDTH +: WIDTH] : '0;
      end
   endgenerate

   always_comb begin
      din_or = '0;
      for (int i = 0; i < NREQ; i++) din_or = din_or | din_sel[i];
   end

   assign k_mem_din = din_or;
   assign req_addr  = (|gnt_reg) ? k_mem_addr : '0;

endmodule

// File: tb/tb_sha3_arbiter.sv
// tb_sha3_arbiter
// Directed bench for sha3_arbiter. Instance u_dut (TMO=64) covers normal
// jobs, contention, routing, request drop and reset; u_dut_tmo (TMO=16)
// has a core that never finishes and covers the watchdog.
module tb_sha3_arbiter;
   import sha3_arb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [1:0]   req, req_b;
   logic [15:0]  req_din;
   logic [7:0]   k_mem_addr;
   logic [511:0] k_out_usr;
   logic         k_out_ready, k_out_ready_b;

   logic [1:0]   gnt, done, err, gnt_b, done_b, err_b;
   logic [511:0] digest, digest_b;
   logic [7:0]   req_addr, req_addr_b, k_mem_din, k_mem_din_b;
   logic         k_rst_b, k_in_ready, k_rst_b_b, k_in_ready_b;

   int checks   = 0;
   int failures = 0;

   localparam logic [511:0] DIG_A = {64{8'hA5}};
   localparam logic [511:0] DIG_R = {64{8'h3C}};
   localparam logic [511:0] DIG_1 = {32{16'h1234}};
   localparam logic [511:0] DIG_2 = {16{32'hDEADBEEF}};
   localparam logic [511:0] DIG_3 = {64{8'h5A}};
   localparam logic [511:0] DIG_4 = {8{64'h0123456789ABCDEF}};

   sha3_arbiter #(.NREQ(2), .WIDTH(8), .AW(8), .TMO(64)) u_dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done), .err(err),
      .digest(digest), .req_addr(req_addr), .req_din(req_din),
      .k_rst_b(k_rst_b), .k_in_ready(k_in_ready), .k_mem_addr(k_mem_addr),
      .k_mem_din(k_mem_din), .k_out_usr(k_out_usr), .k_out_ready(k_out_ready)
   );

   sha3_arbiter #(.NREQ(2), .WIDTH(8), .AW(8), .TMO(16)) u_dut_tmo (
      .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .done(done_b), .err(err_b),
      .digest(digest_b), .req_addr(req_addr_b), .req_din(req_din),
      .k_rst_b(k_rst_b_b), .k_in_ready(k_in_ready_b), .k_mem_addr(k_mem_addr),
      .k_mem_din(k_mem_din_b), .k_out_usr(k_out_usr), .k_out_ready(k_out_ready_b)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full job on u_dut, starting with req already applied in IDLE.
   // The core answers lat cycles after k_in_ready; drop is cleared from req
   // in the third BUSY cycle.
   task automatic run_job(input logic [1:0] g, input int lat,
                          input logic [511:0] dig, input logic [1:0] drop);
      int extra;
      tick();
      check("clr_gnt", gnt, g);
      check("clr_rstb", k_rst_b, 1'b0);
      tick();
      check("launch_inrdy", k_in_ready, 1'b1);
      check("launch_rstb", k_rst_b, 1'b1);
      extra = 0;
      for (int i = 1; i <= lat; i++) begin
         tick();
         if (done != 2'b00 || err != 2'b00 || k_in_ready || !k_rst_b || gnt != g) extra++;
         if (i == 1) begin
            check("route_addr", req_addr, 8'h13);
            check("route_din", k_mem_din, g[1] ? 8'h77 : 8'h22);
         end
         if (i == 3) req = req & ~drop;
         if (i == lat) begin
            k_out_ready = 1'b1;
            k_out_usr   = dig;
         end
      end
      check("busy_quiet", extra, 0);
      tick();
      k_out_ready = 1'b0;
      k_out_usr   = ~dig;
      check("done_pulse", done, g);
      check("done_digest", digest, dig);
      check("done_gnt", gnt, g);
      tick();
      check("idle_gnt", gnt, 2'b00);
      check("idle_done", done, 2'b00);
      check("idle_addr", req_addr, 8'h00);
      check("idle_din", k_mem_din, 8'h00);
      check("digest_hold", digest, dig);
      $display("job gnt=%b lat=%0d digest=%0h", g, lat, digest[31:0]);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int early;
      rst = 1'b1; req = 2'b00; req_b = 2'b00;
      k_out_ready = 1'b0; k_out_ready_b = 1'b0; k_out_usr = '0;
      k_mem_addr = 8'h13; req_din = 16'h7722;

      tick(); tick();
      check("rst_gnt", gnt, 2'b00);
      check("rst_done", done, 2'b00);
      check("rst_err", err, 2'b00);
      check("rst_digest", digest, '0);
      check("rst_rstb", k_rst_b, 1'b0);
      check("rst_inrdy", k_in_ready, 1'b0);
      rst = 1'b0;
      tick();
      check("idle_rstb", k_rst_b, 1'b1);
      check("idle_gnt0", gnt, 2'b00);

      // single request
      req = 2'b01;
      run_job(2'b01, 30, DIG_A, 2'b00);
      req = 2'b00;
      tick();
      check("stay_idle", gnt, 2'b00);

      // routing on requester 1 (ptr is now 1)
      req = 2'b10;
      run_job(2'b10, 5, DIG_R, 2'b00);
      req = 2'b00;

      // contention, ptr back at 0
      req = 2'b11;
      run_job(2'b01, 4, DIG_1, 2'b00);
      run_job(2'b10, 6, DIG_2, 2'b00);
      run_job(2'b01, 3, DIG_3, 2'b00);
      req = 2'b00;

      // request drop mid-BUSY (ptr=1, search wraps to 0)
      req = 2'b01;
      run_job(2'b01, 8, DIG_4, 2'b01);

      // watchdog on the TMO=16 instance
      req_b = 2'b11;
      tick();
      check("tmo_gnt", gnt_b, 2'b01);
      tick();
      check("tmo_launch", k_in_ready_b, 1'b1);
      early = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i < 16 && err_b != 2'b00) early++;
         if (i == 16) begin
            check("tmo_err", err_b, 2'b01);
            check("tmo_nodone", done_b, 2'b00);
            check("tmo_gnt_held", gnt_b, 2'b01);
         end
      end
      check("tmo_early", early, 0);
      tick();
      check("tmo_err_clr", err_b, 2'b00);
      check("tmo_gnt_clr", gnt_b, 2'b00);
      check("tmo_digest", digest_b, '0);
      tick();
      check("tmo_next_gnt", gnt_b, 2'b10);
      $display("timeout err after 16 busy cycles, next gnt=%b", gnt_b);
      req_b = 2'b00;

      // reset mid-job
      req = 2'b01;
      tick();
      check("rj_gnt", gnt, 2'b01);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      check("rj_gnt0", gnt, 2'b00);
      check("rj_done", done, 2'b00);
      check("rj_err", err, 2'b00);
      check("rj_digest", digest, '0);
      check("rj_inrdy", k_in_ready, 1'b0);
      check("rj_rstb", k_rst_b, 1'b0);
      check("rj_addr", req_addr, 8'h00);
      tick();
      check("rj_rstb_hold", k_rst_b, 1'b0);
      rst = 1'b0;
      req = 2'b10;
      tick();
      check("rj_first_gnt", gnt, 2'b10);
      $display("reset mid-job, first grant after release=%b", gnt);
      req = 2'b00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
